// File: rtl/vsrb_pipe_if.sv
// vsrb_pipe_if
//   Groups the operand-side and result-side valid/ready handshakes of the
//   vsrb_pipe byte-lane shift-right unit into one bundle.
//   Signals:
//     in_valid/in_ready   operand handshake (producer -> unit)
//     op_alg              0 = logical (zero fill), 1 = algebraic (sign fill)
//     vra/vrb             source data and per-lane shift amounts
//     out_valid/out_ready result handshake (unit -> consumer)
//     vrt/vlost           shifted result and per-lane lost-bit flags
//   Modports:
//     master  producer/consumer side (drives operands, accepts results)
//     slave   the shift unit itself
interface vsrb_pipe_if #(
   parameter int NLANE = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 op_alg;
   logic [8*NLANE-1:0]   vra;
   logic [8*NLANE-1:0]   vrb;
   logic                 out_valid;
   logic                 out_ready;
   logic [8*NLANE-1:0]   vrt;
   logic [NLANE-1:0]     vlost;

   modport master (
      output in_valid, op_alg, vra, vrb, out_ready,
      input  in_ready, out_valid, vrt, vlost
   );

   modport slave (
      input  in_valid, op_alg, vra, vrb, out_ready,
      output in_ready, out_valid, vrt, vlost
   );
endinterface

// File: rtl/vsrb_pipe.sv
// vsrb_pipe
//   Pipelined byte-lane vector shift-right (vsrb logical / vsrab algebraic).
//   Each 8-bit lane of vra is shifted right by the low 3 bits of the matching
//   lane of vrb. Stage 1 does the coarse shift by 4, stage 2 the fine shift
//   by 0..3; both accumulate the bits shifted out into a per-lane lost flag.
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    vsrb_pipe_if.slave (operand and result handshakes)
module vsrb_pipe #(
   parameter int NLANE = 4
) (
   input logic          clk,
   input logic          rst_n,
   vsrb_pipe_if.slave   bus
);

   localparam int W = 8 * NLANE;

   // Coarse step: shift one lane by 4 when sh[2] is set. Returns {lost, data}.
   function automatic logic [8:0] coarseLane(input logic [7:0] v,
                                             input logic [2:0] sh,
                                             input logic       alg);
      logic fill;
      fill = alg & v[7];
      if (sh[2])
         return {|v[3:0], {4{fill}}, v[7:4]};
      else
         return {1'b0, v};
   endfunction

   // Fine step: shift one lane by 0..3 and fold newly lost bits into lostIn.
   // After a coarse shift the lane MSB still carries the original sign.
   function automatic logic [8:0] fineLane(input logic [7:0] v,
                                           input logic [1:0] sh,
                                           input logic       alg,
                                           input logic       lostIn);
      logic [7:0] res;
      logic [7:0] mask;
      if (alg)
         res = $signed(v) >>> sh;
      else
         res = v >> sh;
      mask = (8'd1 << sh) - 8'd1;
      return {lostIn | (|(v & mask)), res};
   endfunction

   logic             s1Valid_q;
   logic             s1Alg_q;
   logic [W-1:0]     s1Data_q;
   logic [2*NLANE-1:0] s1Fine_q;
   logic [NLANE-1:0] s1Lost_q;
   logic             s2Valid_q;
   logic [W-1:0]     vrt_q;
   logic [NLANE-1:0] vlost_q;

   logic [W-1:0]       coarseData_d;
   logic [NLANE-1:0]   coarseLost_d;
   logic [2*NLANE-1:0] fineSh_d;
   logic [W-1:0]       fineData_d;
   logic [NLANE-1:0]   fineLost_d;

   logic adv1;
   logic adv2;
   logic inXfer;
   logic unusedVrbBits;

   // A stage may take new data when it is empty or its contents move on.
   // in_ready therefore depends only on the valid flags and out_ready.
   assign adv2   = !s2Valid_q | bus.out_ready;
   assign adv1   = !s1Valid_q | adv2;
   assign inXfer = bus.in_valid & adv1;

   assign bus.in_ready  = adv1;
   assign bus.out_valid = s2Valid_q;
   assign bus.vrt       = vrt_q;
   assign bus.vlost     = vlost_q;

   // Only bits [2:0] of each vrb lane matter; the rest are deliberately dropped.
   assign unusedVrbBits = ^bus.vrb;

   // Stage 1 combinational work: coarse shift per lane and capture of the
   // remaining fine shift amount for stage 2.
   always_comb begin
      coarseData_d = '0;
      coarseLost_d = '0;
      fineSh_d     = '0;
      for (int i = 0; i < NLANE; i++) begin
         {coarseLost_d[i], coarseData_d[8*i +: 8]} =
            coarseLane(bus.vra[8*i +: 8], bus.vrb[8*i +: 3], bus.op_alg);
         fineSh_d[2*i +: 2] = bus.vrb[8*i +: 2];
      end
   end

   // Stage 2 combinational work: fine shift of the stage-1 lanes.
   always_comb begin
      fineData_d = '0;
      fineLost_d = '0;
      for (int i = 0; i < NLANE; i++) begin
         {fineLost_d[i], fineData_d[8*i +: 8]} =
            fineLane(s1Data_q[8*i +: 8], s1Fine_q[2*i +: 2], s1Alg_q, s1Lost_q[i]);
      end
   end

   // Stage 1 register: load on an input transfer, otherwise empty out when
   // the contents have moved into stage 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q <= 1'b0;
         s1Alg_q   <= 1'b0;
         s1Data_q  <= '0;
         s1Fine_q  <= '0;
         s1Lost_q  <= '0;
      end else if (inXfer) begin
         s1Valid_q <= 1'b1;
         s1Alg_q   <= bus.op_alg;
         s1Data_q  <= coarseData_d;
         s1Fine_q  <= fineSh_d;
         s1Lost_q  <= coarseLost_d;
      end else if (adv1) begin
         s1Valid_q <= 1'b0;
      end
   end

   // Stage 2 register: holds the result stable until the consumer takes it,
   // and can accept stage 1 in the same cycle it hands a result off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2Valid_q <= 1'b0;
         vrt_q     <= '0;
         vlost_q   <= '0;
      end else if (adv2 && s1Valid_q) begin
         s2Valid_q <= 1'b1;
         vrt_q     <= fineData_d;
         vlost_q   <= fineLost_d;
      end else if (adv2) begin
         s2Valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vsrb_pipe.sv
// tb_vsrb_pipe
//   Self-checking bench for vsrb_pipe: directed vectors, backpressure,
//   streaming with random operands and reset in mid-operation. Expected
//   results come from a per-lane integer model of the shift-right rules.
module tb_vsrb_pipe;

   logic clk;
   logic rst_n;
   int   testCount;
   int   failCount;

   vsrb_pipe_if #(.NLANE(4)) bus ();

   vsrb_pipe #(.NLANE(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: each lane treated as an integer, divided by 2^sh
   // rounding toward minus infinity; lost means a nonzero remainder.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input logic alg,
                                 output logic [31:0] r, output logic [3:0] l);
      r = '0;
      l = '0;
      for (int i = 0; i < 4; i++) begin
         int v;
         int s;
         int sv;
         int q;
         v  = int'(a[8*i +: 8]);
         s  = int'(b[8*i +: 3]);
         sv = (alg && v >= 128) ? v - 256 : v;
         q  = sv >>> s;
         r[8*i +: 8] = 8'(q);
         l[i] = (v % (1 << s)) != 0;
      end
   endfunction

   task automatic setOp(input logic valid, input logic [31:0] a,
                        input logic [31:0] b, input logic alg);
      bus.in_valid = valid;
      bus.vra      = a;
      bus.vrb      = b;
      bus.op_alg   = alg;
   endtask

   // Reset state and in_ready after release.
   task automatic test_reset;
      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      setOp(1'b0, '0, '0, 1'b0);
      #12;
      testCount++;
      if (bus.out_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid);
      end
      testCount++;
      if (bus.vrt !== 32'h0 || bus.vlost !== 4'h0) begin
         failCount++;
         $display("[TB] FAIL reset_vrt got %h/%b want 0/0", bus.vrt, bus.vlost);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      testCount++;
      if (bus.in_ready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready);
      end
      testCount++;
      if (bus.out_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_idle_valid got %b want 0", bus.out_valid);
      end
   endtask

   // One op with out_ready high; checks the 2-cycle latency and the result.
   task automatic runSingle(input string name, input logic [31:0] a,
                            input logic [31:0] b, input logic alg,
                            input logic [31:0] expR, input logic [3:0] expL);
      @(negedge clk);
      bus.out_ready = 1'b1;
      setOp(1'b1, a, b, alg);
      testCount++;
      if (bus.in_ready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL %s_in_ready got %b want 1", name, bus.in_ready);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      testCount++;
      if (bus.out_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL %s_early_valid got %b want 0", name, bus.out_valid);
      end
      @(negedge clk);
      testCount++;
      if (bus.out_valid !== 1'b1 || bus.vrt !== expR || bus.vlost !== expL) begin
         failCount++;
         $display("[TB] FAIL %s_result got v=%b %h/%b want v=1 %h/%b",
                  name, bus.out_valid, bus.vrt, bus.vlost, expR, expL);
      end
      @(negedge clk);
      testCount++;
      if (bus.out_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL %s_drain got %b want 0", name, bus.out_valid);
      end
   endtask

   task automatic test_directed;
      logic [31:0] r;
      logic [3:0]  l;
      runSingle("t1_logical", 32'h80F00F81, 32'h07040301, 1'b0, 32'h010F0140, 4'b0011);
      runSingle("t2_algebraic", 32'h80F00F81, 32'h07040301, 1'b1, 32'hFFFF01C0, 4'b0011);
      runSingle("t3_ignored", 32'h12345678, 32'hF8F8F8F8, 1'b0, 32'h12345678, 4'b0000);
      for (int k = 0; k < 4; k++) begin
         logic [31:0] a;
         logic [31:0] b;
         logic        alg;
         a   = $urandom;
         b   = $urandom;
         alg = 1'($urandom_range(0, 1));
         model(a, b, alg, r, l);
         runSingle("rand_single", a, b, alg, r, l);
      end
   endtask

   // Three back-to-back ops against a stalled consumer.
   task automatic test_backpressure;
      logic [31:0] a [3];
      logic [31:0] b [3];
      logic        alg [3];
      logic [31:0] r [3];
      logic [3:0]  l [3];
      for (int k = 0; k < 3; k++) begin
         a[k]   = $urandom;
         b[k]   = $urandom;
         alg[k] = 1'($urandom_range(0, 1));
         model(a[k], b[k], alg[k], r[k], l[k]);
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         setOp(1'b1, a[k], b[k], alg[k]);
         testCount++;
         if (bus.in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL bp_accept%0d got %b want 1", k, bus.in_ready);
         end
         @(negedge clk);
      end
      setOp(1'b1, a[2], b[2], alg[2]);
      testCount++;
      if (bus.in_ready !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL bp_third_ready got %b want 0", bus.in_ready);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         testCount++;
         if (bus.out_valid !== 1'b1 || bus.vrt !== r[0] || bus.vlost !== l[0]
             || bus.in_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL bp_stall got v=%b rdy=%b %h/%b want v=1 rdy=0 %h/%b",
                     bus.out_valid, bus.in_ready, bus.vrt, bus.vlost, r[0], l[0]);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      for (int k = 1; k < 3; k++) begin
         @(negedge clk);
         testCount++;
         if (bus.out_valid !== 1'b1 || bus.vrt !== r[k] || bus.vlost !== l[k]) begin
            failCount++;
            $display("[TB] FAIL bp_order%0d got v=%b %h/%b want v=1 %h/%b",
                     k, bus.out_valid, bus.vrt, bus.vlost, r[k], l[k]);
         end
      end
      @(negedge clk);
      testCount++;
      if (bus.out_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL bp_drain got %b want 0", bus.out_valid);
      end
   endtask

   // Eight random ops back-to-back with the consumer always ready.
   task automatic test_streaming;
      logic [35:0] expQ [$];
      int got;
      int firstCyc;
      int lastCyc;
      got      = 0;
      firstCyc = -1;
      lastCyc  = -1;
      @(negedge clk);
      bus.out_ready = 1'b1;
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               logic [31:0] a;
               logic [31:0] b;
               logic        alg;
               logic [31:0] r;
               logic [3:0]  l;
               a   = $urandom;
               b   = $urandom;
               alg = 1'($urandom_range(0, 1));
               model(a, b, alg, r, l);
               expQ.push_back({l, r});
               setOp(1'b1, a, b, alg);
               @(negedge clk);
            end
            bus.in_valid = 1'b0;
         end
         begin
            for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
               @(negedge clk);
               if (bus.out_valid === 1'b1) begin
                  logic [35:0] e;
                  e = (expQ.size() > 0) ? expQ.pop_front() : 36'h0;
                  if (firstCyc < 0) firstCyc = cyc;
                  lastCyc = cyc;
                  got++;
                  testCount++;
                  if (bus.vrt !== e[31:0] || bus.vlost !== e[35:32]) begin
                     failCount++;
                     $display("[TB] FAIL stream%0d got %h/%b want %h/%b",
                              got, bus.vrt, bus.vlost, e[31:0], e[35:32]);
                  end
               end
            end
         end
      join
      testCount++;
      if (got != 8 || lastCyc - firstCyc != 7) begin
         failCount++;
         $display("[TB] FAIL stream_rate got %0d results over %0d cycles want 8 over 8",
                  got, lastCyc - firstCyc + 1);
      end
   endtask

   // Reset asserted with both stages full; nothing may come out afterwards.
   task automatic test_reset_midop;
      logic [31:0] r;
      logic [3:0]  l;
      @(negedge clk);
      bus.out_ready = 1'b0;
      setOp(1'b1, 32'hDEADBEEF, 32'h01020304, 1'b1);
      @(negedge clk);
      setOp(1'b1, 32'hCAFEF00D, 32'h05060700, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      testCount++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL midop_full got v=%b rdy=%b want v=1 rdy=0",
                  bus.out_valid, bus.in_ready);
      end
      rst_n = 1'b0;
      #1;
      testCount++;
      if (bus.out_valid !== 1'b0 || bus.vrt !== 32'h0 || bus.vlost !== 4'h0) begin
         failCount++;
         $display("[TB] FAIL midop_reset got v=%b %h/%b want v=0 0/0",
                  bus.out_valid, bus.vrt, bus.vlost);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         testCount++;
         if (bus.out_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midop_stale%0d got %b want 0", c, bus.out_valid);
         end
      end
      model(32'h7F80FF01, 32'h03020100, 1'b1, r, l);
      runSingle("midop_after", 32'h7F80FF01, 32'h03020100, 1'b1, r, l);
   endtask

   initial begin
      testCount = 0;
      failCount = 0;
      test_reset();
      test_directed();
      test_backpressure();
      test_streaming();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
